// File: rtl/encout_reg_blk_mc.sv
// Multi-channel register block for the encoder-output subsystem: per-channel
// control, double-buffered timing registers, W1C sticky status and interrupts.
module encout_reg_blk_mc #(
  parameter int          NCH     = 2,
  parameter int          CW      = 16,
  parameter logic [31:0] VERSION = 32'h00030001
) (
  input  logic              i_pclk,
  input  logic              i_presetn,
  input  logic [7:0]        i_addr,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_rvalid,
  input  logic [NCH-1:0]    i_elc_err,
  input  logic [NCH*CW-1:0] i_period_aset,
  input  logic [NCH-1:0]    i_period_aset_vld,
  input  logic [NCH-1:0]    i_upd,
  input  logic [NCH*CW-1:0] i_reg_poscnt,
  output logic [NCH*5-1:0]  o_reg_ctl,
  output logic [NCH-1:0]    o_reg_str,
  output logic [NCH-1:0]    o_reg_opt,
  output logic [NCH*CW-1:0] o_reg_period,
  output logic [NCH*CW-1:0] o_reg_posmax,
  output logic [NCH*CW-1:0] o_reg_outcnt,
  output logic [NCH-1:0]    o_wr_poscnt,
  output logic [NCH-1:0]    o_irq
);
  // Timing register slots: 0 POSMAX, 1 OUTCNT, 2 PERIOD
  localparam int NT = 3;

  logic [3:0] chf, idx;
  logic       glob;
  assign chf  = i_addr[7:4];
  assign idx  = i_addr[3:0];
  assign glob = (chf == 4'hF);

  logic [NCH-1:0] str_q, opt_q, irq_q;
  logic [4:0]     ctl_q  [NCH];
  logic [2:0]     ien_q  [NCH];
  logic [2:0]     sts_q  [NCH];
  logic [NT-1:0]  pend_q [NCH];
  logic [CW-1:0]  sh_q   [NCH][NT];
  logic [CW-1:0]  act_q  [NCH][NT];
  logic [31:0]    rdata_q;
  logic           rvalid_q;

  logic [NCH-1:0] wr_ch, str_clr, aset;
  logic [NT-1:0]  tim_we  [NCH];
  logic [2:0]     sts_set [NCH];
  logic [2:0]     sts_clr [NCH];
  logic [31:0]    rd_mux;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, i_wdata[31:CW]};

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_ch[c]   = i_wr && (chf == 4'(c));
      str_clr[c] = i_wr && glob && (idx == 4'd0) && str_q[c] && !i_wdata[c];
      aset[c]    = opt_q[c] && i_period_aset_vld[c];
      tim_we[c][0] = wr_ch[c] && (idx == 4'd2);
      tim_we[c][1] = wr_ch[c] && (idx == 4'd3);
      tim_we[c][2] = wr_ch[c] && (idx == 4'd4) && !opt_q[c];
      sts_set[c] = {aset[c], (act_q[c][1] > act_q[c][2]), i_elc_err[c]};
      sts_clr[c] = (wr_ch[c] && (idx == 4'd6)) ? i_wdata[2:0] : 3'b000;
      // Gated by reset so a write strobe held through reset never leaks out
      o_wr_poscnt[c] = i_presetn && wr_ch[c] && (idx == 4'd5) && !str_q[c];
    end
  end

  // Timing registers read back their active copy
  always_comb begin
    rd_mux = '0;
    if (glob) begin
      case (idx)
        4'd0:    rd_mux[NCH-1:0] = str_q;
        4'd1:    rd_mux = VERSION;
        4'd2:    rd_mux[NCH-1:0] = irq_q;
        default: rd_mux = '0;
      endcase
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (chf == 4'(c)) begin
          case (idx)
            4'd0:    rd_mux[4:0]    = ctl_q[c];
            4'd1:    rd_mux[0]      = opt_q[c];
            4'd2:    rd_mux[CW-1:0] = act_q[c][0];
            4'd3:    rd_mux[CW-1:0] = act_q[c][1];
            4'd4:    rd_mux[CW-1:0] = act_q[c][2];
            4'd5:    rd_mux[CW-1:0] = i_reg_poscnt[c*CW +: CW];
            4'd6:    rd_mux[3:0]    = {|pend_q[c], sts_q[c]};
            4'd7:    rd_mux[2:0]    = ien_q[c];
            default: rd_mux = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_pclk or negedge i_presetn) begin
    if (!i_presetn) begin
      str_q    <= '0;
      opt_q    <= '0;
      irq_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ctl_q[c]  <= '0;
        ien_q[c]  <= '0;
        sts_q[c]  <= '0;
        pend_q[c] <= '0;
        for (int t = 0; t < NT; t++) begin
          sh_q[c][t]  <= '0;
          act_q[c][t] <= '0;
        end
      end
    end else begin
      rvalid_q <= i_rd;
      if (i_rd) rdata_q <= rd_mux;
      if (i_wr && glob && (idx == 4'd0)) str_q <= i_wdata[NCH-1:0];
      for (int c = 0; c < NCH; c++) begin
        if (wr_ch[c] && !str_q[c] && (idx == 4'd0)) ctl_q[c] <= i_wdata[4:0];
        if (wr_ch[c] && !str_q[c] && (idx == 4'd1)) opt_q[c] <= i_wdata[0];
        if (wr_ch[c] && (idx == 4'd7))              ien_q[c] <= i_wdata[2:0];
        // Set beats a simultaneous write-1-to-clear
        sts_q[c] <= (sts_q[c] & ~sts_clr[c]) | sts_set[c];
        irq_q[c] <= |(sts_q[c] & ien_q[c]);
        for (int t = 0; t < NT; t++) begin
          if (tim_we[c][t]) begin
            sh_q[c][t] <= i_wdata[CW-1:0];
            if (!str_q[c] || i_upd[c]) begin
              act_q[c][t]  <= i_wdata[CW-1:0];
              pend_q[c][t] <= 1'b0;
            end else begin
              pend_q[c][t] <= 1'b1;
            end
          end else if (pend_q[c][t] && (i_upd[c] || str_clr[c])) begin
            act_q[c][t]  <= sh_q[c][t];
            pend_q[c][t] <= 1'b0;
          end
        end
        // Auto-acquired period bypasses buffering entirely
        if (aset[c]) begin
          sh_q[c][2]   <= i_period_aset[c*CW +: CW];
          act_q[c][2]  <= i_period_aset[c*CW +: CW];
          pend_q[c][2] <= 1'b0;
        end
      end
    end
  end

  assign o_rdata   = rdata_q;
  assign o_rvalid  = rvalid_q;
  assign o_reg_str = str_q;
  assign o_reg_opt = opt_q;
  assign o_irq     = irq_q;

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign o_reg_ctl[c*5 +: 5]     = ctl_q[c];
    assign o_reg_posmax[c*CW +: CW] = act_q[c][0];
    assign o_reg_outcnt[c*CW +: CW] = act_q[c][1];
    assign o_reg_period[c*CW +: CW] = act_q[c][2];
  end
endmodule

// File: tb/tb_encout_reg_blk_mc.sv
// Directed bench for encout_reg_blk_mc: read responses go through a scoreboard
// queue checked by an independent monitor; register outputs are checked directly.
module tb_encout_reg_blk_mc;
  localparam int NCH = 2;
  localparam int CW  = 16;

  logic              i_pclk = 1'b0;
  logic              i_presetn = 1'b0;
  logic [7:0]        i_addr = '0;
  logic              i_wr = 1'b0;
  logic              i_rd = 1'b0;
  logic [31:0]       i_wdata = '0;
  logic [31:0]       o_rdata;
  logic              o_rvalid;
  logic [NCH-1:0]    i_elc_err = '0;
  logic [NCH*CW-1:0] i_period_aset = '0;
  logic [NCH-1:0]    i_period_aset_vld = '0;
  logic [NCH-1:0]    i_upd = '0;
  logic [NCH*CW-1:0] i_reg_poscnt = '0;
  logic [NCH*5-1:0]  o_reg_ctl;
  logic [NCH-1:0]    o_reg_str;
  logic [NCH-1:0]    o_reg_opt;
  logic [NCH*CW-1:0] o_reg_period;
  logic [NCH*CW-1:0] o_reg_posmax;
  logic [NCH*CW-1:0] o_reg_outcnt;
  logic [NCH-1:0]    o_wr_poscnt;
  logic [NCH-1:0]    o_irq;

  encout_reg_blk_mc #(.NCH(NCH), .CW(CW), .VERSION(32'h00030001)) dut (
    .i_pclk(i_pclk), .i_presetn(i_presetn), .i_addr(i_addr), .i_wr(i_wr),
    .i_rd(i_rd), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_rvalid(o_rvalid),
    .i_elc_err(i_elc_err), .i_period_aset(i_period_aset),
    .i_period_aset_vld(i_period_aset_vld), .i_upd(i_upd),
    .i_reg_poscnt(i_reg_poscnt), .o_reg_ctl(o_reg_ctl), .o_reg_str(o_reg_str),
    .o_reg_opt(o_reg_opt), .o_reg_period(o_reg_period),
    .o_reg_posmax(o_reg_posmax), .o_reg_outcnt(o_reg_outcnt),
    .o_wr_poscnt(o_wr_poscnt), .o_irq(o_irq)
  );

  always #5 i_pclk = ~i_pclk;

  typedef struct { logic [7:0] addr; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endfunction

  // Monitor: every o_rvalid pops one expected response
  always @(negedge i_pclk) begin
    if (o_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid actual=%h expected=no_response", o_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("rdata@%h", e.addr), o_rdata, e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_pclk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    i_addr = a; i_wdata = d; i_wr = 1'b1;
    tick(1);
    i_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp);
    exp_t e;
    e.addr = a; e.data = exp;
    exp_q.push_back(e);
    i_addr = a; i_rd = 1'b1;
    tick(1);
    i_rd = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(3);
    #2 i_presetn = 1'b1;
    tick(1);
    chk("rst_period", o_reg_period, 0);
    chk("rst_ctl", o_reg_ctl, 0);
    chk("rst_irq", o_irq, 0);
    chk("rst_str", o_reg_str, 0);
    rd(8'hF1, 32'h00030001);
    tick(1);

    // Ch1 double buffering via i_upd and via STR clear
    wr(8'h14, 100);
    chk("ch1_period_direct", o_reg_period[31:16], 100);
    wr(8'hF0, 2);
    chk("str_out", o_reg_str, 2'b10);
    wr(8'h14, 200);
    chk("ch1_period_held", o_reg_period[31:16], 100);
    rd(8'h16, 32'h8);
    i_upd = 2'b10; tick(1); i_upd = 2'b00;
    chk("ch1_period_upd", o_reg_period[31:16], 200);
    rd(8'h16, 32'h0);
    rd(8'hF0, 32'h2);
    wr(8'h12, 16'h77);
    chk("ch1_posmax_held", o_reg_posmax[31:16], 0);
    wr(8'hF0, 0);
    chk("ch1_posmax_strclr", o_reg_posmax[31:16], 16'h77);

    // Ch0 CTL/POSCNT lockout while started
    wr(8'hF0, 1);
    wr(8'h00, 32'h1F);
    chk("ctl_locked", o_reg_ctl[4:0], 0);
    i_addr = 8'h05; i_wdata = 32'h55; i_wr = 1'b1;
    #2 chk("poscnt_pulse_locked", o_wr_poscnt, 2'b00);
    tick(1); i_wr = 1'b0;
    wr(8'hF0, 0);
    wr(8'h00, 32'h1F);
    chk("ctl_written", o_reg_ctl[4:0], 5'h1F);
    i_addr = 8'h05; i_wdata = 32'h55; i_wr = 1'b1;
    #2 chk("poscnt_pulse", o_wr_poscnt, 2'b01);
    tick(1); i_wr = 1'b0;
    i_reg_poscnt = {16'hBEEF, 16'h0123};
    rd(8'h05, 32'h0123);
    rd(8'h15, 32'hBEEF);
    rd(8'h26, 32'h0);
    rd(8'h18, 32'h0);

    // OUTCNT_ERR sticky, set beats W1C, interrupt
    wr(8'h04, 50);
    wr(8'h03, 60);
    wr(8'h07, 2);
    tick(1);
    chk("irq_outcnt_err", o_irq, 2'b01);
    rd(8'h06, 32'h2);
    wr(8'h06, 2);
    rd(8'h06, 32'h2);
    wr(8'h03, 40);
    chk("outcnt_40", o_reg_outcnt[15:0], 40);
    wr(8'h06, 2);
    tick(1);
    chk("irq_cleared", o_irq, 2'b00);
    rd(8'h06, 32'h0);
    // Read+write together returns pre-write value
    i_addr = 8'h07; i_wdata = 3; i_wr = 1'b1; i_rd = 1'b1;
    exp_q.push_back('{addr: 8'h07, data: 32'h2});
    tick(1); i_wr = 1'b0; i_rd = 1'b0;
    rd(8'h07, 32'h3);

    // Auto-period mode
    wr(8'h01, 1);
    chk("opt_out", o_reg_opt, 2'b01);
    i_period_aset = {16'h0, 16'h1234}; i_period_aset_vld = 2'b01;
    tick(1); i_period_aset_vld = 2'b00;
    chk("aset_period", o_reg_period[15:0], 16'h1234);
    rd(8'h06, 32'h4);
    wr(8'h04, 99);
    chk("aset_wr_ignored", o_reg_period[15:0], 16'h1234);

    // ELC error coincident with W1C of bit0
    i_elc_err = 2'b01;
    wr(8'h06, 1);
    i_elc_err = 2'b00;
    rd(8'h06, 32'h5);
    tick(1);
    chk("irq_elc", o_irq, 2'b01);
    rd(8'hF2, 32'h1);
    tick(2);

    // Reset in the middle of a read: response is dropped
    i_addr = 8'hF1; i_rd = 1'b1;
    #2 i_presetn = 1'b0;
    tick(1); i_rd = 1'b0;
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_irq2", o_irq, 0);
    chk("rst_period2", o_reg_period, 0);
    chk("rst_outcnt2", o_reg_outcnt, 0);
    chk("rst_ctl2", o_reg_ctl, 0);
    chk("rst_opt2", o_reg_opt, 0);
    tick(2);
    i_presetn = 1'b1;
    tick(3);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick(1);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/encout_reg_blk_mc.md
# encout_reg_blk_mc

Multi-channel, parametrised register block for the encoder-output subsystem. It decodes a single APB-side address/strobe interface into NCH independent channel register sets, each feeding one PHASE_GEN instance. It adds two behaviours: double-buffered timing registers that update on a period boundary while running, and write-1-to-clear sticky status with per-channel interrupts.

## Interface
- NCH, 2, number of channels (1..8)
- CW, 16, counter/compare width (8..16); CW-bit fields are zero-extended to 32 on read
- VERSION, 32'h00030001, value of the VER register
- i_pclk  in  1  clock
- i_presetn  in  1  reset; asynchronous, active-low; all flops clear on assertion
- i_addr  in  8  word address: [7:4] channel field (4'hF = global), [3:0] register index
- i_wr  in  1  write strobe, one cycle per access
- i_rd  in  1  read strobe, one cycle per access
- i_wdata  in  32  write data
- o_rdata  out  32  registered read data
- o_rvalid  out  1  one-cycle pulse, o_rdata valid
- i_elc_err  in  NCH  per-channel ELC error pulse
- i_period_aset  in  NCH*CW  auto-acquired period, channel c at [c*CW +: CW]
- i_period_aset_vld  in  NCH  auto-acquire valid
- i_upd  in  NCH  period-boundary pulse from PHASE_GEN
- i_reg_poscnt  in  NCH*CW  live position counter
- o_reg_ctl  out  NCH*5  CTL per channel
- o_reg_str  out  NCH  start bits
- o_reg_opt  out  NCH  auto-period mode
- o_reg_period, o_reg_posmax, o_reg_outcnt  out  NCH*CW each  active (not shadow) values
- o_wr_poscnt  out  NCH  POSCNT write pulse; data is i_wdata[CW-1:0] in the same cycle
- o_irq  out  NCH  registered level interrupt

## Operation
- Channel register indices: 0 CTL[4:0], 1 OPT[0], 2 POSMAX, 3 OUTCNT, 4 PERIOD, 5 POSCNT (write pulse, read live i_reg_poscnt), 6 STATUS, 7 IEN[2:0].
- Global indices: 0 STR[NCH-1:0] (R/W), 1 VER (RO), 2 IRQ summary = o_irq (RO).
- Channel field >= NCH (except F), or an unlisted index: read 0, write ignored.
- CTL, OPT, POSCNT writes are ignored while STR[c]=1.
- Timing registers (POSMAX, OUTCNT, PERIOD) each have a shadow, an active copy and a pending bit.
  - STR[c]=0: write loads shadow and active.
  - STR[c]=1: write loads shadow only and sets pending.
  - i_upd[c] with pending set: active <= shadow, pending cleared.
  - Write coincident with i_upd[c]: active takes i_wdata directly; pending is cleared.
  - STR write clearing bit c: all pending shadows of c load into active on that same edge.
- PERIOD write is ignored when OPT[c]=1. In that mode, i_period_aset_vld[c] loads shadow and active immediately (no buffering) and sets ASET_DONE.
- STATUS bits:
  - [0] ELC_ERR: sticky, set by i_elc_err.
  - [1] OUTCNT_ERR: sticky, set when active OUTCNT > active PERIOD (unsigned CW-bit compare, evaluated every cycle).
  - [2] ASET_DONE: sticky.
  - [3] PEND: read-only OR of the three pending bits.
  - Bits [2:0] are write-1-to-clear. A set condition in the same cycle as a W1C wins.
- o_irq[c] <= |(STATUS[2:0] & IEN[2:0]).
- Reads never clear state.

## Timing
- Write: takes effect at the edge where i_wr=1. Outputs change the following cycle.
- Read: data is sampled at the edge where i_rd=1. o_rdata/o_rvalid appear one cycle later. o_rvalid is high for exactly one cycle. o_rdata holds until the next read.
- i_wr and i_rd together: the write is performed, and the read returns the pre-write value.
- Shadow to active transfer: active value is visible on the output one cycle after the i_upd edge.
- Status set: visible the cycle after the event. o_irq follows one cycle after that.
- o_wr_poscnt is combinational from i_wr, decode and ~STR. It is never asserted on a reset edge.
- Reset (any time, including mid-access): every register, pending bit, o_rdata, o_rvalid and o_irq go to 0. o_reg_* outputs are 0. A read in flight is dropped (no o_rvalid).

## Test plan
- Reset, read global VER (addr 0xF1) -> o_rvalid one cycle later, o_rdata=32'h00030001. All o_reg_* are 0.
- Ch1, STR=0, write PERIOD=100 -> o_reg_period[ch1]=100 next cycle. Set STR=2'b10, write PERIOD=200 -> stays 100 and STATUS.PEND=1. Pulse i_upd[1] -> 200 and PEND=0.
- Ch0 STR=1, write CTL=5'h1F and POSCNT -> CTL unchanged, o_wr_poscnt[0] never asserted. Clear STR -> write accepted.
- Ch0 PERIOD=50, write OUTCNT=60 -> OUTCNT_ERR=1. With IEN=3'b010, o_irq[0]=1. Write STATUS=2 while error persists -> bit stays 1. Write OUTCNT=40, then W1C -> bit=0, irq=0.
- OPT=1, i_period_aset_vld with 16'h1234 -> active PERIOD=16'h1234 and ASET_DONE=1. An APB PERIOD write in that state is ignored.
- i_elc_err coincident with STATUS W1C of bit0 -> bit0 remains 1. Assert i_presetn low mid-read -> no o_rvalid, all outputs 0.
